adc_scan_seq: RTL and testbench

- Conversion sequencer for the 10-bit SAR ADC core.
- Generates the st_conv sampling/conversion pulse and drives the analog input mux select.
- Runs a pending comparator-offset calibration before a scan and re-resets the ADC core when the step mode changes.
- Returns one 10-bit result per enabled channel over a valid/ready handshake. Sits between the digital host logic and the ADC core/front-end mux.

---
 rtl/adc_scan_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_adc_scan_seq.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_seq.sv
// adc_scan_seq: conversion sequencer for the 10-bit SAR ADC core.
//
// Walks the enabled channels of a latched mask, one conversion per channel. Each
// conversion holds st_conv high for SAMPLE_CYC cycles and then waits for the ADC's
// asynchronous adc_done. A pending offset calibration runs as an extra conversion
// (cal=1) ahead of a scan. A change of the requested step mode re-resets the ADC core
// before any further scan is accepted.
//
// Ports:
//   clkin, rst            controller clock, asynchronous active-high reset
//   start, ch_mask        one-cycle scan request and channel enable mask (sampled at start)
//   cal_req               one-cycle calibration request (held pending until next start)
//   mode_12b              requested ADC step mode, acted on only while idle
//   st_conv, cal,         ADC controls: sample/convert strobe, calibration select,
//   sel_12b, adc_rst      step mode, ADC core reset
//   ch_sel                analog input mux select
//   adc_done, adc_result  ADC completion (asynchronous) and 10-bit result
//   res_valid/ready/data  result handshake; res_ch is the channel of res_data
//   busy                  high while a calibration or scan is in progress
//   cal_done              one-cycle pulse when the calibration conversion completes
//   timeout_err           sticky; set on a conversion timeout, cleared by the next start
module adc_scan_seq #(
   parameter int unsigned NCH        = 4,
   parameter int unsigned CHW        = 2,
   parameter int unsigned SAMPLE_CYC = 4,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned RST_CYC    = 2
) (
   input  logic           clkin,
   input  logic           rst,
   input  logic           start,
   input  logic [NCH-1:0] ch_mask,
   input  logic           cal_req,
   input  logic           mode_12b,
   output logic           st_conv,
   output logic           cal,
   output logic           sel_12b,
   output logic           adc_rst,
   output logic [CHW-1:0] ch_sel,
   input  logic           adc_done,
   input  logic [9:0]     adc_result,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [9:0]     res_data,
   output logic [CHW-1:0] res_ch,
   output logic           busy,
   output logic           cal_done,
   output logic           timeout_err
);

   // One counter serves the ADC reset, sample and timeout phases.
   localparam int unsigned CntMax = TIMEOUT + SAMPLE_CYC + RST_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYC - 1);
   localparam logic [CntW-1:0] SampLast = CntW'(SAMPLE_CYC - 1);
   localparam logic [CntW-1:0] ToLast   = CntW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StArst,
      StIdle,
      StCsamp,
      StCconv,
      StSamp,
      StConv,
      StOut
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]  mask_q, mask_d;
   logic [CHW-1:0]  ch_sel_q, ch_sel_d;
   logic            cal_pend_q, cal_pend_d;
   logic            sel_12b_q, sel_12b_d;
   logic            st_conv_q, st_conv_d;
   logic            cal_q, cal_d;
   logic            adc_rst_q, adc_rst_d;
   logic            busy_q, busy_d;
   logic            res_valid_q, res_valid_d;
   logic [9:0]      res_data_q, res_data_d;
   logic [CHW-1:0]  res_ch_q, res_ch_d;
   logic            cal_done_q, cal_done_d;
   logic            timeout_err_q, timeout_err_d;

   // adc_done synchronizer; the third flop only remembers the previous synchronized
   // value for rising-edge detection.
   logic done_s1_q, done_s1_d;
   logic done_s2_q, done_s2_d;
   logic done_s3_q, done_s3_d;
   logic done_rise;

   assign done_s1_d = adc_done;
   assign done_s2_d = done_s1_q;
   assign done_s3_d = done_s2_q;
   assign done_rise = done_s2_q & ~done_s3_q;

   // Channel search helpers. Loops run downwards so the lowest qualifying bit wins.
   logic           first_found;
   logic [CHW-1:0] first_ch;
   logic [CHW-1:0] scan_first_ch;
   logic           next_found;
   logic [CHW-1:0] next_ch;

   always_comb begin
      first_found   = 1'b0;
      first_ch      = '0;
      scan_first_ch = '0;
      next_found    = 1'b0;
      next_ch       = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            first_found = 1'b1;
            first_ch    = CHW'(i);
         end
         if (mask_q[i]) begin
            scan_first_ch = CHW'(i);
         end
         if (mask_q[i] && (i > int'(ch_sel_q))) begin
            next_found = 1'b1;
            next_ch    = CHW'(i);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mask_d        = mask_q;
      ch_sel_d      = ch_sel_q;
      cal_pend_d    = cal_pend_q;
      sel_12b_d     = sel_12b_q;
      res_data_d    = res_data_q;
      res_ch_d      = res_ch_q;
      cal_done_d    = 1'b0;
      timeout_err_d = timeout_err_q;

      unique case (state_q)
         StArst: begin
            if (cnt_q == RstLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StIdle: begin
            cnt_d = '0;
            // A mode change wins over a same-cycle start; that start is lost.
            if (mode_12b != sel_12b_q) begin
               state_d   = StArst;
               sel_12b_d = mode_12b;
            end else if (start && first_found) begin
               mask_d        = ch_mask;
               ch_sel_d      = first_ch;
               timeout_err_d = 1'b0;
               state_d       = cal_pend_q ? StCsamp : StSamp;
            end
         end

         StCsamp, StSamp: begin
            if (cnt_q == SampLast) begin
               cnt_d   = '0;
               state_d = (state_q == StCsamp) ? StCconv : StConv;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StCconv: begin
            if (done_rise) begin
               cal_done_d = 1'b1;
               cal_pend_d = 1'b0;
               ch_sel_d   = scan_first_ch;
               cnt_d      = '0;
               state_d    = StSamp;
            end else if (cnt_q == ToLast) begin
               // cal_pend stays set so the calibration is retried at the next start.
               timeout_err_d = 1'b1;
               cnt_d         = '0;
               state_d       = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StConv: begin
            if (done_rise) begin
               res_data_d = adc_result;
               res_ch_d   = ch_sel_q;
               cnt_d      = '0;
               state_d    = StOut;
            end else if (cnt_q == ToLast) begin
               timeout_err_d = 1'b1;
               cnt_d         = '0;
               state_d       = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StOut: begin
            if (res_ready) begin
               cnt_d = '0;
               if (next_found) begin
                  ch_sel_d = next_ch;
                  state_d  = StSamp;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StArst;
            cnt_d   = '0;
         end
      endcase

      // Requests arriving at any time are remembered; set wins over a same-cycle clear.
      if (cal_req) begin
         cal_pend_d = 1'b1;
      end
   end

   // Registered outputs decoded from the next state. busy stays low in ARST, which is
   // housekeeping rather than a scan.
   always_comb begin
      st_conv_d   = (state_d == StSamp) || (state_d == StCsamp);
      cal_d       = (state_d == StCsamp) || (state_d == StCconv);
      adc_rst_d   = (state_d == StArst);
      busy_d      = (state_d != StIdle) && (state_d != StArst);
      res_valid_d = (state_d == StOut);
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_q       <= StArst;
         cnt_q         <= '0;
         mask_q        <= '0;
         ch_sel_q      <= '0;
         cal_pend_q    <= 1'b0;
         sel_12b_q     <= 1'b0;
         st_conv_q     <= 1'b0;
         cal_q         <= 1'b0;
         adc_rst_q     <= 1'b1;
         busy_q        <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_ch_q      <= '0;
         cal_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         done_s1_q     <= 1'b0;
         done_s2_q     <= 1'b0;
         done_s3_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         ch_sel_q      <= ch_sel_d;
         cal_pend_q    <= cal_pend_d;
         sel_12b_q     <= sel_12b_d;
         st_conv_q     <= st_conv_d;
         cal_q         <= cal_d;
         adc_rst_q     <= adc_rst_d;
         busy_q        <= busy_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_ch_q      <= res_ch_d;
         cal_done_q    <= cal_done_d;
         timeout_err_q <= timeout_err_d;
         done_s1_q     <= done_s1_d;
         done_s2_q     <= done_s2_d;
         done_s3_q     <= done_s3_d;
      end
   end

   assign st_conv     = st_conv_q;
   assign cal         = cal_q;
   assign sel_12b     = sel_12b_q;
   assign adc_rst     = adc_rst_q;
   assign ch_sel      = ch_sel_q;
   assign busy        = busy_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_ch      = res_ch_q;
   assign cal_done    = cal_done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_seq.sv
// tb_adc_scan_seq: self-checking bench for adc_scan_seq.
// A behavioural ADC answers each conversion with the analog value of the selected
// channel; expected results are queued per scan from the mask and a monitor pops
// and compares them at every result handshake.
module tb_adc_scan_seq;
   localparam int NCH        = 4;
   localparam int CHW        = 2;
   localparam int SAMPLE_CYC = 4;
   localparam int TIMEOUT    = 64;
   localparam int RST_CYC    = 2;

   logic           clkin = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [NCH-1:0] ch_mask = '0;
   logic           cal_req = 1'b0;
   logic           mode_12b = 1'b0;
   logic           adc_done = 1'b0;
   logic [9:0]     adc_result = '0;
   logic           res_ready = 1'b0;
   logic           st_conv, cal, sel_12b, adc_rst, res_valid, busy, cal_done, timeout_err;
   logic [CHW-1:0] ch_sel, res_ch;
   logic [9:0]     res_data;

   adc_scan_seq #(
      .NCH(NCH), .CHW(CHW), .SAMPLE_CYC(SAMPLE_CYC), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)
   ) dut (
      .clkin(clkin), .rst(rst), .start(start), .ch_mask(ch_mask), .cal_req(cal_req),
      .mode_12b(mode_12b), .st_conv(st_conv), .cal(cal), .sel_12b(sel_12b),
      .adc_rst(adc_rst), .ch_sel(ch_sel), .adc_done(adc_done), .adc_result(adc_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
      .busy(busy), .cal_done(cal_done), .timeout_err(timeout_err)
   );

   always #5 clkin = ~clkin;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #2;
   endtask

   // ---------------- environment state ----------------
   logic [9:0] analog [NCH];
   bit         adc_dead = 1'b0;
   bit         rdy_rand = 1'b0;
   bit         rdy_force = 1'b1;

   typedef struct packed {
      logic [CHW-1:0] ch;
      logic [9:0]     data;
   } res_t;

   res_t           sb[$];
   logic [CHW-1:0] obs_ch[$];
   logic           obs_cal[$];
   int             rise_cnt = 0;
   int             cal_done_cnt = 0;

   // Reference: a scan yields one result per set mask bit, lowest channel first.
   task automatic push_expected(input logic [NCH-1:0] m);
      res_t e;
      for (int i = 0; i < NCH; i++) begin
         if (m[i]) begin
            e.ch   = CHW'(i);
            e.data = analog[i];
            sb.push_back(e);
         end
      end
   endtask

   // ---------------- ready driver ----------------
   initial begin
      forever begin
         @(posedge clkin);
         #2;
         res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   end

   // ---------------- behavioural ADC ----------------
   logic           m_prev = 1'b0;
   int             m_cd = 0;
   logic [CHW-1:0] m_ch = '0;

   initial begin
      forever begin
         @(negedge clkin);
         if (rst) begin
            m_prev   = 1'b0;
            m_cd     = 0;
            adc_done = 1'b0;
         end else begin
            if (st_conv && !m_prev) begin
               adc_done = 1'b0;
               m_ch     = ch_sel;
               m_cd     = 0;
            end else if (!st_conv && m_prev) begin
               if (!adc_dead) m_cd = $urandom_range(1, 8);
            end else if (m_cd > 0) begin
               m_cd--;
               if (m_cd == 0) begin
                  adc_result = analog[m_ch];
                  adc_done   = 1'b1;
               end
            end
            m_prev = st_conv;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic           mon_st_prev = 1'b0;
   int             mon_width = 0;
   logic           hold_v = 1'b0;
   logic [9:0]     hold_data = '0;
   logic [CHW-1:0] hold_ch = '0;
   res_t           exp_r;

   initial begin
      forever begin
         @(negedge clkin);
         if (rst) begin
            mon_st_prev = 1'b0;
            mon_width   = 0;
            hold_v      = 1'b0;
         end else begin
            if (st_conv && !mon_st_prev) begin
               rise_cnt++;
               obs_ch.push_back(ch_sel);
               obs_cal.push_back(cal);
               mon_width = 1;
               chk("no_conv_while_result_pending", int'(res_valid), 0);
            end else if (st_conv) begin
               mon_width++;
            end
            if (!st_conv && mon_st_prev) chk("st_conv_width", mon_width, SAMPLE_CYC);
            mon_st_prev = st_conv;

            if (hold_v) begin
               chk("res_valid_held", int'(res_valid), 1);
               chk("res_data_held", int'(res_data), int'(hold_data));
               chk("res_ch_held", int'(res_ch), int'(hold_ch));
            end
            hold_v    = res_valid && !res_ready;
            hold_data = res_data;
            hold_ch   = res_ch;

            if (res_valid && res_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", int'(res_valid), 0);
               end else begin
                  exp_r = sb.pop_front();
                  chk("res_ch", int'(res_ch), int'(exp_r.ch));
                  chk("res_data", int'(res_data), int'(exp_r.data));
               end
            end
            if (cal_done) cal_done_cnt++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start(input logic [NCH-1:0] m);
      ch_mask = m;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      ch_mask = NCH'($urandom);  // later mask changes must not matter
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      chk({name, "_terminates"}, int'(busy), 0);
      chk({name, "_all_results"}, sb.size(), 0);
   endtask

   task automatic wait_adc_rst_low();
      int n = 0;
      while (adc_rst && n < 20) begin
         tick();
         n++;
      end
      chk("adc_rst_releases", int'(adc_rst), 0);
   endtask

   task automatic randomize_analog();
      for (int i = 0; i < NCH; i++) analog[i] = 10'($urandom);
   endtask

   // ---------------- main sequence ----------------
   int             n;
   int             r0;
   int             c0;
   logic [NCH-1:0] m;
   bit             cal_m;
   bit             this_cal;

   initial begin
      randomize_analog();

      // Reset values.
      repeat (3) @(posedge clkin);
      #2;
      chk("rst_st_conv", int'(st_conv), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_adc_rst", int'(adc_rst), 1);
      chk("rst_timeout_err", int'(timeout_err), 0);
      chk("rst_sel_12b", int'(sel_12b), 0);
      chk("rst_res_data", int'(res_data), 0);
      chk("rst_cal", int'(cal), 0);
      @(negedge clkin);
      rst = 1'b0;
      n = 0;
      while (adc_rst && n < 10) begin
         tick();
         n++;
      end
      chk("adc_rst_cycles_after_reset", n, RST_CYC);
      chk("busy_after_reset", int'(busy), 0);

      // Empty mask is ignored.
      r0 = rise_cnt;
      pulse_start('0);
      repeat (8) tick();
      chk("mask0_no_conversion", rise_cnt, r0);
      chk("mask0_not_busy", int'(busy), 0);

      // Two-channel scan, ADC returns 100 + channel.
      for (int i = 0; i < NCH; i++) analog[i] = 10'(100 + i);
      obs_ch.delete();
      obs_cal.delete();
      sb.push_back('{ch: 2'd1, data: 10'd101});
      sb.push_back('{ch: 2'd3, data: 10'd103});
      pulse_start(4'b1010);
      chk("start_to_st_conv_next_cycle", int'(st_conv), 1);
      chk("busy_in_scan", int'(busy), 1);
      wait_idle("scan1010");
      chk("scan1010_conversions", obs_ch.size(), 2);
      if (obs_ch.size() == 2) begin
         chk("scan1010_ch_sel_first", int'(obs_ch[0]), 1);
         chk("scan1010_ch_sel_second", int'(obs_ch[1]), 3);
      end

      // Calibration ahead of the scan, then none on the following scan.
      randomize_analog();
      cal_req = 1'b1;
      tick();
      cal_req = 1'b0;
      c0 = cal_done_cnt;
      obs_cal.delete();
      push_expected(4'b0001);
      pulse_start(4'b0001);
      chk("cal_high_in_cal_sample", int'(cal), 1);
      wait_idle("cal_scan");
      chk("cal_done_pulses", cal_done_cnt - c0, 1);
      chk("cal_scan_conversions", obs_cal.size(), 2);
      if (obs_cal.size() == 2) begin
         chk("cal_first_conv_is_cal", int'(obs_cal[0]), 1);
         chk("cal_second_conv_not_cal", int'(obs_cal[1]), 0);
      end
      obs_cal.delete();
      push_expected(4'b0001);
      pulse_start(4'b0001);
      wait_idle("after_cal_scan");
      chk("no_repeat_cal", obs_cal.size(), 1);
      if (obs_cal.size() == 1) chk("no_repeat_cal_flag", int'(obs_cal[0]), 0);
      chk("no_repeat_cal_done", cal_done_cnt - c0, 1);

      // Back-pressure: ready low for 10 cycles in OUT.
      randomize_analog();
      rdy_force = 1'b0;
      push_expected(4'b0101);
      pulse_start(4'b0101);
      n = 0;
      while (!res_valid && n < 300) begin
         tick();
         n++;
      end
      chk("bp_result_arrives", int'(res_valid), 1);
      r0 = rise_cnt;
      repeat (10) tick();
      chk("bp_valid_still_high", int'(res_valid), 1);
      chk("bp_no_next_conversion", rise_cnt, r0);
      rdy_force = 1'b1;
      wait_idle("bp_scan");

      // Timeout: ADC never completes.
      adc_dead = 1'b1;
      pulse_start(4'b0001);
      n = 0;
      while (st_conv && n < 20) begin
         tick();
         n++;
      end
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk("timeout_window", int'(n >= TIMEOUT - 2 && n <= TIMEOUT + 2), 1);
      chk("timeout_err_set", int'(timeout_err), 1);
      chk("timeout_idle", int'(busy), 0);
      chk("timeout_no_result", int'(res_valid), 0);
      adc_dead = 1'b0;
      randomize_analog();
      push_expected(4'b0010);
      pulse_start(4'b0010);
      chk("timeout_err_cleared_by_start", int'(timeout_err), 0);
      wait_idle("after_timeout_scan");

      // Asynchronous reset mid-CONV.
      adc_dead = 1'b1;
      pulse_start(4'b0001);
      n = 0;
      while (st_conv && n < 20) begin
         tick();
         n++;
      end
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("rst_conv_busy", int'(busy), 0);
      chk("rst_conv_st_conv", int'(st_conv), 0);
      chk("rst_conv_adc_rst", int'(adc_rst), 1);
      adc_dead = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      wait_adc_rst_low();

      // Asynchronous reset while a result is pending: it is discarded.
      randomize_analog();
      rdy_force = 1'b0;
      pulse_start(4'b0001);
      n = 0;
      while (!res_valid && n < 300) begin
         tick();
         n++;
      end
      chk("rst_out_result_arrives", int'(res_valid), 1);
      rst = 1'b1;
      #1;
      chk("rst_out_res_valid", int'(res_valid), 0);
      chk("rst_out_res_data", int'(res_data), 0);
      chk("rst_out_busy", int'(busy), 0);
      sb.delete();
      rdy_force = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      wait_adc_rst_low();

      // Mode change while idle: wins over a same-cycle start.
      r0 = rise_cnt;
      mode_12b = 1'b1;
      ch_mask  = 4'b0001;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("mode_sel_12b", int'(sel_12b), 1);
      chk("mode_adc_rst", int'(adc_rst), 1);
      chk("mode_busy", int'(busy), 0);
      n = 0;
      while (adc_rst && n < 10) begin
         tick();
         n++;
      end
      chk("mode_adc_rst_cycles", n, RST_CYC);
      repeat (4) tick();
      chk("mode_start_dropped", rise_cnt, r0);
      randomize_analog();
      push_expected(4'b1000);
      pulse_start(4'b1000);
      wait_idle("after_mode_scan");
      chk("mode_sel_12b_kept", int'(sel_12b), 1);

      // Randomized scans with random ready and calibration requests.
      rdy_rand = 1'b1;
      cal_m    = 1'b0;
      for (int it = 0; it < 25; it++) begin
         randomize_analog();
         m = NCH'($urandom_range(1, (1 << NCH) - 1));
         if ($urandom_range(0, 2) == 0) begin
            cal_req = 1'b1;
            tick();
            cal_req = 1'b0;
            cal_m   = 1'b1;
         end
         this_cal = cal_m;
         cal_m    = 1'b0;
         c0 = cal_done_cnt;
         obs_cal.delete();
         push_expected(m);
         pulse_start(m);
         if (!this_cal && $urandom_range(0, 3) == 0) begin
            tick();
            tick();
            cal_req = 1'b1;
            tick();
            cal_req = 1'b0;
            cal_m   = 1'b1;
         end
         wait_idle("rand_scan");
         chk("rand_conversions", obs_cal.size(), $countones(m) + int'(this_cal));
         if (obs_cal.size() > 0) chk("rand_cal_first", int'(obs_cal[0]), int'(this_cal));
         chk("rand_cal_done", cal_done_cnt - c0, int'(this_cal));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
